clusterv_dmareq_sched: RTL and testbench

//  Round-robin scheduler that shares one DMA channel among the peripheral DMA request lines.
//  It sits between the SPI tx/rx ready lines and the DMA request inputs of the peripheral subsystem.
//  - Grants one requester at a time with a bounded burst.
//  - Enforces a holdoff gap between grants.
//  - Aborts and flags a grant that receives no DMA ack within a timeout.

---
 rtl/clusterv_dmareq_sched.sv | 141 ++++++++++++++
 tb/tb_clusterv_dmareq_sched.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/clusterv_dmareq_sched.sv
// Round-robin scheduler sharing one DMA channel among N_REQ request lines.
// It grants one requester at a time, limits the burst, inserts a holdoff gap and flags ack timeouts.
module clusterv_dmareq_sched #(
  parameter int N_REQ       = 4,
  parameter int BURST_W     = 8,
  parameter int TIMEOUT_W   = 12,
  parameter int HOLDOFF_CYC = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_i,
  input  logic [N_REQ-1:0]           enable_i,
  input  logic [BURST_W-1:0]         burst_len_i,
  input  logic [N_REQ-1:0]           dma_ack_i,
  input  logic [N_REQ-1:0]           err_clr_i,
  output logic [N_REQ-1:0]           dma_req_o,
  output logic [$clog2(N_REQ)-1:0]   grant_id_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [N_REQ-1:0]           err_o,
  output logic [1:0]                 dbg_state_o
);

  localparam int IDW = $clog2(N_REQ);
  localparam int HW  = $clog2(HOLDOFF_CYC + 1);
  localparam logic [TIMEOUT_W-1:0] TMR_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t               r_state;
  logic [IDW-1:0]       r_last;
  logic [IDW-1:0]       r_gid;
  logic [N_REQ-1:0]     r_req;
  logic                 r_busy;
  logic                 r_done;
  logic [N_REQ-1:0]     r_err;
  logic [BURST_W-1:0]   r_cnt;
  logic [BURST_W-1:0]   r_blen;
  logic [TIMEOUT_W-1:0] r_tmr;
  logic [HW-1:0]        r_hcnt;

  logic [N_REQ-1:0]     w_elig;
  logic                 w_found;
  logic [IDW-1:0]       w_pick;
  logic [IDW-1:0]       w_idx;
  logic                 w_ack;
  logic                 w_cnt_hit;
  logic                 w_drop;
  logic                 w_tout;
  logic                 w_release;
  logic [N_REQ-1:0]     w_err_set;

  assign w_elig = req_i & enable_i;

  // Scan starts just after the last granted index so every requester gets a turn.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      w_idx = IDW'((int'(r_last) + i) % N_REQ);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  assign w_ack     = dma_ack_i[r_gid];
  assign w_cnt_hit = (r_blen != '0) && w_ack && (r_cnt == r_blen - BURST_W'(1));
  assign w_drop    = !req_i[r_gid] || !enable_i[r_gid];
  assign w_tout    = !w_ack && (r_tmr == TMR_LAST);
  assign w_release = w_cnt_hit || w_drop || w_tout;
  assign w_err_set = (r_state == S_GRANT && w_tout) ? (N_REQ'(1) << r_gid) : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_last  <= IDW'(N_REQ - 1);
      r_gid   <= '0;
      r_req   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= '0;
      r_cnt   <= '0;
      r_blen  <= '0;
      r_tmr   <= '0;
      r_hcnt  <= '0;
    end else begin
      r_done <= 1'b0;
      // A timeout set on the same bit as a clear takes priority.
      r_err  <= (r_err & ~err_clr_i) | w_err_set;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_GRANT;
            r_req   <= N_REQ'(1) << w_pick;
            r_gid   <= w_pick;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_tmr   <= '0;
            r_blen  <= burst_len_i;
          end
        end
        S_GRANT: begin
          if (w_ack) begin
            r_tmr <= '0;
            if (r_cnt != '1) r_cnt <= r_cnt + BURST_W'(1);
          end else if (r_tmr != '1) begin
            r_tmr <= r_tmr + TIMEOUT_W'(1);
          end
          if (w_release) begin
            r_state <= S_HOLD;
            r_req   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_last  <= r_gid;
            r_hcnt  <= '0;
          end
        end
        S_HOLD: begin
          if (r_hcnt == HW'(HOLDOFF_CYC - 1)) r_state <= S_IDLE;
          else                                r_hcnt  <= r_hcnt + HW'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dma_req_o   = r_req;
  assign grant_id_o  = r_gid;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_clusterv_dmareq_sched.sv
// Directed bench for clusterv_dmareq_sched: grant order, burst length, holdoff gap,
// timeout flagging, enable drop, asynchronous reset and stray acks.
module tb_clusterv_dmareq_sched;

  logic       clock;
  logic       reset;
  logic [3:0] req_i;
  logic [3:0] enable_i;
  logic [7:0] burst_len_i;
  logic [3:0] dma_ack_i;
  logic [3:0] err_clr_i;
  logic [3:0] dma_req_o;
  logic [1:0] grant_id_o;
  logic       busy_o;
  logic       done_o;
  logic [3:0] err_o;
  logic [1:0] dbg_state_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  clusterv_dmareq_sched #(
    .N_REQ(4), .BURST_W(8), .TIMEOUT_W(12), .HOLDOFF_CYC(2)
  ) dut (
    .clock(clock), .reset(reset), .req_i(req_i), .enable_i(enable_i),
    .burst_len_i(burst_len_i), .dma_ack_i(dma_ack_i), .err_clr_i(err_clr_i),
    .dma_req_o(dma_req_o), .grant_id_o(grant_id_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .dbg_state_o(dbg_state_o)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic wait_rise(input int budget, output int cyc);
    cyc = 0;
    while (dma_req_o == 4'd0 && cyc < budget) begin
      tick();
      cyc++;
    end
    if (dma_req_o == 4'd0) chk("rise_bound", 32'd0, 32'd1);
  endtask

  task automatic wait_fall(input int budget, output int cyc);
    cyc = 0;
    while (dma_req_o != 4'd0 && cyc < budget) begin
      tick();
      cyc++;
    end
    if (dma_req_o != 4'd0) chk("fall_bound", 32'd0, 32'd1);
  endtask

  task automatic grant_round(input string tag, input int e, input int exp_len, input bit first);
    int c;
    logic [3:0] onehot;
    onehot = 4'd1 << e;
    wait_rise(20, c);
    if (first) chk({tag, "_lat"}, c, 1);
    else       chk({tag, "_gap"}, c + 1, 3);
    chk({tag, "_id"}, 32'(grant_id_o), e);
    chk({tag, "_req"}, 32'(dma_req_o), 32'(onehot));
    chk({tag, "_busy"}, 32'(busy_o), 1);
    wait_fall(20, c);
    chk({tag, "_len"}, c, exp_len);
    chk({tag, "_done"}, 32'(done_o), 1);
    chk({tag, "_busy_lo"}, 32'(busy_o), 0);
    tick();
    chk({tag, "_done_pulse"}, 32'(done_o), 0);
  endtask

  initial begin
    int c;
    bit first;
    reset = 1'b1; req_i = '0; enable_i = '0; burst_len_i = '0;
    dma_ack_i = '0; err_clr_i = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_req", 32'(dma_req_o), 0);
    chk("rst_gid", 32'(grant_id_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_state", 32'(dbg_state_o), 0);

    // Two requesters, burst of 2, ack every cycle: 0,2,0,2.
    enable_i = 4'hF; req_i = 4'b0101; burst_len_i = 8'd2; dma_ack_i = 4'b0101;
    exp_q = '{0, 2, 0, 2};
    first = 1'b1;
    while (exp_q.size() > 0) begin
      grant_round("t1", exp_q.pop_front(), 2, first);
      first = 1'b0;
    end
    req_i = '0; dma_ack_i = '0;
    repeat (4) tick();

    // Unlimited burst on requester 1, released when its request drops.
    req_i = 4'b0010; burst_len_i = 8'd0;
    wait_rise(20, c);
    chk("t2_lat", c, 1);
    chk("t2_id", 32'(grant_id_o), 1);
    dma_ack_i = 4'b0010;
    repeat (5) tick();
    chk("t2_hold", 32'(dma_req_o), 32'h2);
    req_i = '0; dma_ack_i = '0;
    tick();
    chk("t2_rel", 32'(dma_req_o), 0);
    chk("t2_done", 32'(done_o), 1);
    chk("t2_err", 32'(err_o), 0);
    repeat (4) tick();

    // Requester 3 never acked: timeout after 4095 cycles.
    req_i = 4'b1000; burst_len_i = 8'd4;
    wait_rise(20, c);
    chk("t3_id", 32'(grant_id_o), 3);
    wait_fall(5000, c);
    chk("t3_tout_len", c, 4095);
    chk("t3_err", 32'(err_o), 32'h8);
    chk("t3_done", 32'(done_o), 1);
    req_i = '0;
    tick();
    chk("t3_err_sticky", 32'(err_o), 32'h8);
    err_clr_i = 4'b1000;
    tick();
    err_clr_i = '0;
    chk("t3_err_clr", 32'(err_o), 0);
    repeat (3) tick();

    // Requester 0 disabled: 1,2,3,1; then drop enable of 2 mid-grant.
    enable_i = 4'b1110; req_i = 4'hF; burst_len_i = 8'd1; dma_ack_i = 4'hF;
    exp_q = '{1, 2, 3, 1};
    first = 1'b1;
    while (exp_q.size() > 0) begin
      grant_round("t4", exp_q.pop_front(), 1, first);
      first = 1'b0;
    end
    burst_len_i = 8'd0;
    wait_rise(20, c);
    chk("t4_gap5", c + 1, 3);
    chk("t4_id5", 32'(grant_id_o), 2);
    repeat (3) tick();
    chk("t4_unlim", 32'(dma_req_o), 32'h4);
    enable_i = 4'b1010;
    tick();
    chk("t4_en_rel", 32'(dma_req_o), 0);
    chk("t4_en_done", 32'(done_o), 1);
    req_i = '0; enable_i = 4'hF; dma_ack_i = '0;
    repeat (4) tick();

    // Asynchronous reset during a burst.
    req_i = 4'b0001; burst_len_i = 8'd3;
    wait_rise(20, c);
    chk("t5_id", 32'(grant_id_o), 0);
    dma_ack_i = 4'b0001;
    tick();
    dma_ack_i = '0;
    chk("t5_mid", 32'(dma_req_o), 32'h1);
    reset = 1'b1;
    #1;
    chk("t5_async_req", 32'(dma_req_o), 0);
    chk("t5_async_busy", 32'(busy_o), 0);
    chk("t5_async_state", 32'(dbg_state_o), 0);
    tick();
    req_i = 4'hF; burst_len_i = 8'd1; reset = 1'b0;
    wait_rise(20, c);
    chk("t5_lat", c, 1);
    chk("t5_first", 32'(grant_id_o), 0);
    req_i = '0;
    tick();
    chk("t5_rel_done", 32'(done_o), 1);
    repeat (4) tick();

    // Stray ack on a non-granted line must not count.
    req_i = 4'b0100; burst_len_i = 8'd1;
    wait_rise(20, c);
    chk("t6_id", 32'(grant_id_o), 2);
    dma_ack_i = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_stray", 32'(dma_req_o), 32'h4);
    end
    dma_ack_i = 4'b0100;
    tick();
    chk("t6_rel", 32'(dma_req_o), 0);
    chk("t6_done", 32'(done_o), 1);
    dma_ack_i = '0; req_i = '0;
    repeat (3) tick();

    // Final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
